mac_reg_host_bridge: RTL and testbench
======================================

MAC_REG_HOST_BRIDGE -- requirements
Module: mac_reg_host_bridge

Interface
REQ-001 Parameter: POLL_LIMIT, 255, maximum number of RMON grant polls before timeout (range 1..255).
REQ-002 Clock and reset SHALL be one clock, with a synchronous, active-high reset.
REQ-003 Ports SHALL be as follows:
- Clk_reg  in  1  single clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = register write, 0 = register read.
- req_rmon  in  1  1 = 32-bit RMON counter read; overrides req_write.
- req_addr  in  6  register index, or RMON counter address when req_rmon=1.
- req_wdata  in  16  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  read result; the upper 16 bits are zero for 16-bit reads.
- resp_error  out  1  RMON grant timeout; qualified by resp_valid.
- CSB  out  1  register-file chip select, active low.
- WRB  out  1  register-file write strobe, active low; 1 = read.
- CA  out  8  register byte address = {index[6:0],1'b0}.
- CD_in  out  16  write data to the register file.
- CD_out  in  16  registered read data from the register file.

Function
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted in cycle N when req_valid=1 and req_ready=1.
REQ-005 The FSM SHALL have these states: IDLE, WR, RD, RD_CAP, RM_ADDR, RM_APPLY, RM_POLL, RM_POLL_CAP, RM_LO, RM_LO_CAP, RM_HI, RM_HI_CAP, RM_CLR, RESP.
REQ-006 Outside strobe states, the bridge SHALL drive CSB=1, WRB=1, CA=0, CD_in=0.
REQ-007 Each strobe state SHALL last exactly one cycle, with CSB=0 in that cycle only; two strobes are never adjacent without an intervening non-strobe cycle, except RM_ADDR to RM_APPLY.
REQ-008 A write SHALL follow IDLE -> WR -> RESP:
- WR: CSB=0, WRB=0, CA={0,req_addr,0}, CD_in=req_wdata (all captured at acceptance).
- resp_valid in N+2, with resp_data=0.
REQ-009 A read SHALL follow IDLE -> RD -> RD_CAP -> RESP:
- RD: CSB=0, WRB=1.
- RD_CAP: capture CD_out into resp_data[15:0].
- resp_valid in N+3.
REQ-010 An RMON read SHALL perform this sequence:
- RM_ADDR: write index 28 = {10'b0,req_addr}.
- RM_APPLY: write index 29 = 1.
- RM_POLL: read index 30; RM_POLL_CAP tests CD_out[0].
- On bit 0 = 1, go to RM_LO (read index 31), then RM_LO_CAP captures resp_data[15:0].
- RM_HI: read index 32; RM_HI_CAP captures resp_data[31:16].
- RM_CLR: write index 29 = 0, then RESP.
REQ-011 Poll counter (8-bit):
- Cleared on acceptance.
- Incremented on each RM_POLL_CAP that sees grant=0.
- When it reaches POLL_LIMIT, go to RM_CLR with resp_error=1 and resp_data=0.
- Otherwise return to RM_POLL.
REQ-012 A grant seen on the final allowed poll SHALL take precedence over timeout.
REQ-013 resp_valid SHALL be asserted for exactly one cycle (RESP), and RESP SHALL return to IDLE; no response backpressure.
REQ-014 resp_data and resp_error SHALL hold their values until the next acceptance; both are cleared on acceptance.
REQ-015 No address range check: unmapped indices are accessed as given.
REQ-016 Request inputs are sampled only at acceptance; changes afterwards SHALL be ignored.

Reset
REQ-017 On Reset=1 at a clock edge, the following SHALL take effect on the next cycle:
- state=IDLE.
- CSB=1, WRB=1, CA=0, CD_in=0.
- req_ready=1.
- resp_valid=0, resp_data=0, resp_error=0.
- poll counter=0.
REQ-018 Reset mid-operation SHALL abort the access with no resp_valid; any pending strobe is suppressed in the cycle after Reset.

Verification
REQ-019 Write: req_write=1, addr=5, wdata=0x0000 accepted in N -> N+1 CSB=0, WRB=0, CA=0x0A, CD_in=0x0000; N+2 resp_valid=1, resp_error=0.
REQ-020 Read: addr=26, CD_out=0x2710 in N+2 -> N+1 CSB=0, WRB=1, CA=0x34; N+3 resp_valid=1, resp_data=0x00002710.
REQ-021 RMON success: addr=0x11, grant=1 on 3rd poll, index 31=0xBEEF, index 32=0x1234 -> writes 28=0x0011 and 29=1, then three reads of CA=0x3C, then CA=0x3E and CA=0x40, then write 29=0; resp_data=0x1234BEEF, resp_error=0.
REQ-022 RMON timeout: POLL_LIMIT=4, grant held 0 -> exactly 4 polls, then write 29=0; resp_valid with resp_error=1, resp_data=0.
REQ-023 Reset during RM_POLL -> next cycle CSB=1, req_ready=1, no resp_valid; a following read completes normally.
REQ-024 Back-to-back: req_valid held high with two reads -> second accepted only in the cycle after RESP; req_ready=0 throughout the first access.

Source files
------------

// File: rtl/mac_reg_host_bridge_if.sv
// Host request/response and register-file strobe signals of the MAC register bridge.
interface mac_reg_host_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_rmon;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        CSB;
  logic        WRB;
  logic [7:0]  CA;
  logic [15:0] CD_in;
  logic [15:0] CD_out;

  modport slave (
    input  req_valid, req_write, req_rmon, req_addr, req_wdata, CD_out,
    output req_ready, resp_valid, resp_data, resp_error, CSB, WRB, CA, CD_in
  );

  modport master (
    output req_valid, req_write, req_rmon, req_addr, req_wdata, CD_out,
    input  req_ready, resp_valid, resp_data, resp_error, CSB, WRB, CA, CD_in
  );
endinterface

// File: rtl/mac_reg_host_bridge.sv
// Bridges single host requests onto the MAC register-file strobe bus, including
// the multi-step RMON counter read with grant polling and timeout.
module mac_reg_host_bridge #(
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic                  Clk_reg,
  input  logic                  Reset,
  mac_reg_host_bridge_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, WR, RD, RD_CAP, RM_ADDR, RM_APPLY, RM_POLL, RM_POLL_CAP,
    RM_LO, RM_LO_CAP, RM_HI, RM_HI_CAP, RM_CLR, RESP
  } state_t;

  localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);

  state_t      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  poll_q, poll_d;
  logic        armed_q, armed_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        csb, wrb;
  logic [6:0]  idx;
  logic [15:0] cd;
  logic [7:0]  poll_inc;

  assign poll_inc = poll_q + 8'd1;

  always_ff @(posedge Clk_reg) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      poll_q  <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      poll_q  <= poll_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    poll_d  = poll_q;
    armed_d = armed_q;
    data_d  = data_q;
    err_d   = err_q;
    csb     = 1'b1;
    wrb     = 1'b1;
    idx     = '0;
    cd      = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          poll_d  = '0;
          armed_d = 1'b0;
          data_d  = '0;
          err_d   = 1'b0;
          if (bus.req_rmon)       state_d = RM_ADDR;
          else if (bus.req_write) state_d = WR;
          else                    state_d = RD;
        end
      end
      WR: begin
        csb = 1'b0; wrb = 1'b0; idx = {1'b0, addr_q}; cd = wdata_q;
        state_d = RESP;
      end
      RD: begin
        csb = 1'b0; idx = {1'b0, addr_q};
        state_d = RD_CAP;
      end
      RD_CAP: begin
        data_d  = {16'h0000, bus.CD_out};
        state_d = RESP;
      end
      RM_ADDR: begin
        csb = 1'b0; wrb = 1'b0; idx = 7'd28; cd = {10'b0, addr_q};
        state_d = RM_APPLY;
      end
      // The first pass through RM_POLL_CAP (armed_q=0) is an idle separator so
      // the apply write and the first grant poll never strobe back to back.
      RM_APPLY: begin
        csb = 1'b0; wrb = 1'b0; idx = 7'd29; cd = 16'h0001;
        state_d = RM_POLL_CAP;
      end
      RM_POLL: begin
        csb = 1'b0; idx = 7'd30;
        armed_d = 1'b1;
        state_d = RM_POLL_CAP;
      end
      RM_POLL_CAP: begin
        if (!armed_q) begin
          state_d = RM_POLL;
        end else if (bus.CD_out[0]) begin
          state_d = RM_LO;
        end else begin
          poll_d = poll_inc;
          if (poll_inc == LIMIT) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = RM_CLR;
          end else begin
            state_d = RM_POLL;
          end
        end
      end
      RM_LO: begin
        csb = 1'b0; idx = 7'd31;
        state_d = RM_LO_CAP;
      end
      RM_LO_CAP: begin
        data_d[15:0] = bus.CD_out;
        state_d = RM_HI;
      end
      RM_HI: begin
        csb = 1'b0; idx = 7'd32;
        state_d = RM_HI_CAP;
      end
      RM_HI_CAP: begin
        data_d[31:16] = bus.CD_out;
        state_d = RM_CLR;
      end
      RM_CLR: begin
        csb = 1'b0; wrb = 1'b0; idx = 7'd29; cd = 16'h0000;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = data_q;
  assign bus.resp_error = err_q;
  assign bus.CSB        = csb;
  assign bus.WRB        = wrb;
  assign bus.CA         = {idx, 1'b0};
  assign bus.CD_in      = cd;

endmodule

// File: tb/tb_mac_reg_host_bridge.sv
// Directed scoreboard bench for mac_reg_host_bridge with a behavioural register-file model.
module tb_mac_reg_host_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_reg_host_bridge_if bus();

  mac_reg_host_bridge #(.POLL_LIMIT(4)) dut (
    .Clk_reg (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;

  resp_t       exp_resp[$];
  logic [24:0] exp_strb[$];
  logic        mon_en   = 1'b0;
  int          grant_at = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Register file: registered read data, RMON grant appears on poll number grant_at.
  logic [15:0] mem [0:127];
  int          polls = 0;
  always @(posedge clk) begin
    if (!bus.CSB) begin
      if (!bus.WRB) begin
        mem[bus.CA[7:1]] <= bus.CD_in;
        if (bus.CA == 8'h38) polls <= 0;
      end else begin
        case (bus.CA[7:1])
          7'd26: bus.CD_out <= 16'h2710;
          7'd30: begin
            polls <= polls + 1;
            bus.CD_out <= (polls + 1 == grant_at) ? 16'h0001 : 16'h0000;
          end
          7'd31:   bus.CD_out <= 16'hBEEF;
          7'd32:   bus.CD_out <= 16'h1234;
          default: bus.CD_out <= mem[bus.CA[7:1]];
        endcase
      end
    end
  end

  logic       prev_strb = 1'b0;
  logic [7:0] prev_ca   = 8'h00;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!bus.CSB) begin
        logic [31:0] want;
        if (prev_strb) check("strobe_adjacent", {16'h0, prev_ca, bus.CA}, 32'h0000383A);
        want = (exp_strb.size() != 0) ? {7'b0, exp_strb.pop_front()} : 32'hDEAD0000;
        check("strobe", {7'b0, bus.WRB, bus.CA, bus.CD_in}, want);
      end
      prev_strb = !bus.CSB;
      prev_ca   = bus.CA;
      if (bus.resp_valid) begin
        resp_t r;
        if (exp_resp.size() != 0) r = exp_resp.pop_front();
        else begin r.data = 'x; r.err = 1'bx; r.cyc = 0; end
        check("resp_data", bus.resp_data, r.data);
        check("resp_error", {31'b0, bus.resp_error}, {31'b0, r.err});
        if (r.cyc != 0) check("resp_cycle", cyc, r.cyc);
      end
    end
  end

  task automatic exp_write(input logic [5:0] a, input logic [15:0] d);
    exp_strb.push_back({1'b0, 1'b0, a, 1'b0, d});
  endtask

  task automatic exp_read(input logic [5:0] a);
    exp_strb.push_back({1'b1, 1'b0, a, 1'b0, 16'h0000});
  endtask

  task automatic exp_rmon(input logic [5:0] a, input int npoll, input bit granted);
    exp_strb.push_back({1'b0, 8'h38, 10'b0, a});
    exp_strb.push_back({1'b0, 8'h3A, 16'h0001});
    for (int i = 0; i < npoll; i++) exp_strb.push_back({1'b1, 8'h3C, 16'h0000});
    if (granted) begin
      exp_strb.push_back({1'b1, 8'h3E, 16'h0000});
      exp_strb.push_back({1'b1, 8'h40, 16'h0000});
    end
    exp_strb.push_back({1'b0, 8'h3A, 16'h0000});
  endtask

  // Entered and left on a negedge; acc is the acceptance cycle N.
  task automatic send(input logic w, input logic r, input logic [5:0] a, input logic [15:0] d,
                      input logic [31:0] rdata, input logic rerr, input int lat,
                      input bit push_resp, output int acc);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_rmon  = r;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'b0, bus.req_ready}, 32'd1);
    acc = cyc;
    if (push_resp) exp_resp.push_back('{rdata, rerr, (lat != 0) ? cyc + lat : 0});
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_rmon  = 1'b0;
    bus.req_addr  = ~a;
    bus.req_wdata = ~d;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_resp.size() != 0 || exp_strb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_pending", exp_resp.size() + exp_strb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_rmon  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_csb", {31'b0, bus.CSB}, 32'd1);
    check("rst_wrb", {31'b0, bus.WRB}, 32'd1);
    check("rst_ca", {24'b0, bus.CA}, 32'd0);
    check("rst_cd_in", {16'b0, bus.CD_in}, 32'd0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_resp_error", {31'b0, bus.resp_error}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    exp_write(6'd5, 16'h0000);
    send(1'b1, 1'b0, 6'd5, 16'h0000, 32'h0, 1'b0, 2, 1'b1, acc);
    wait_done();

    exp_read(6'd26);
    send(1'b0, 1'b0, 6'd26, 16'h5555, 32'h00002710, 1'b0, 3, 1'b1, acc);
    wait_done();

    exp_write(6'd63, 16'hA5C3);
    send(1'b1, 1'b0, 6'd63, 16'hA5C3, 32'h0, 1'b0, 2, 1'b1, acc);
    wait_done();
    exp_read(6'd63);
    send(1'b0, 1'b0, 6'd63, 16'h0000, 32'h0000A5C3, 1'b0, 3, 1'b1, acc);
    wait_done();

    grant_at = 3;
    exp_rmon(6'h11, 3, 1'b1);
    send(1'b1, 1'b1, 6'h11, 16'hFFFF, 32'h1234BEEF, 1'b0, 0, 1'b1, acc);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_data", bus.resp_data, 32'h1234BEEF);

    grant_at = 4;
    exp_rmon(6'h3F, 4, 1'b1);
    send(1'b0, 1'b1, 6'h3F, 16'h0000, 32'h1234BEEF, 1'b0, 0, 1'b1, acc);
    check("clear_data_on_accept", bus.resp_data, 32'd0);
    wait_done();

    grant_at = 0;
    exp_rmon(6'h2A, 4, 1'b0);
    send(1'b0, 1'b1, 6'h2A, 16'h0000, 32'h0, 1'b1, 0, 1'b1, acc);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_error", {31'b0, bus.resp_error}, 32'd1);

    exp_read(6'd26);
    send(1'b0, 1'b0, 6'd26, 16'h0000, 32'h00002710, 1'b0, 3, 1'b1, acc);
    check("clear_error_on_accept", {31'b0, bus.resp_error}, 32'd0);
    wait_done();

    grant_at = 0;
    exp_strb.push_back({1'b0, 8'h38, 16'h0007});
    exp_strb.push_back({1'b0, 8'h3A, 16'h0001});
    exp_strb.push_back({1'b1, 8'h3C, 16'h0000});
    send(1'b0, 1'b1, 6'd7, 16'h0000, 32'h0, 1'b0, 0, 1'b0, acc);
    n = 0;
    while (!(bus.CSB == 1'b0 && bus.CA == 8'h3C) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_poll", {24'b0, bus.CA}, 32'h3C);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_csb", {31'b0, bus.CSB}, 32'd1);
    check("abort_ready", {31'b0, bus.req_ready}, 32'd1);
    check("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("abort_strobes_left", exp_strb.size(), 32'd0);
    exp_read(6'd26);
    send(1'b0, 1'b0, 6'd26, 16'h0000, 32'h00002710, 1'b0, 3, 1'b1, acc);
    wait_done();

    exp_read(6'd26);
    exp_read(6'd63);
    send(1'b0, 1'b0, 6'd26, 16'h0000, 32'h00002710, 1'b0, 3, 1'b1, acc);
    send(1'b0, 1'b0, 6'd63, 16'h0000, 32'h0000A5C3, 1'b0, 3, 1'b1, acc2);
    check("b2b_accept_cycle", acc2, acc + 4);
    wait_done();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
